// File: rtl/credit_counter_bank.sv
// credit_counter_bank: bank of NUM_VC saturating credit counters, one per virtual
// channel, each bounded by its own credit limit. Counters and limits are loaded
// through a word-wide shift chain.
//
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   enable                allows counter updates from credit/decrement requests
//   config_in(_valid)     config word shifted into VC[NUM_VC-1]
//   config_out(_valid)    chain output (VC[0] count) and pass-through of config_in_valid
//   credit_in_valid/_vc   credit returned for a VC; credit_ack acknowledges it
//   dec_valid/dec_vc      credit consumed by a VC
//   count_out             packed counts, VC i at [i*WIDTH +: WIDTH]
//   credit_avail          bit i set when VC i count is non-zero
//   err_overflow/underflow/bad_vc  sticky error flags
module credit_counter_bank #(
   parameter int unsigned NUM_VC  = 2,
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned VC_BITS = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [WIDTH-1:0]          config_in,
   input  logic                      config_in_valid,
   output logic [WIDTH-1:0]          config_out,
   output logic                      config_out_valid,
   input  logic                      credit_in_valid,
   input  logic [VC_BITS-1:0]        credit_in_vc,
   output logic                      credit_ack,
   input  logic                      dec_valid,
   input  logic [VC_BITS-1:0]        dec_vc,
   output logic [NUM_VC*WIDTH-1:0]   count_out,
   output logic [NUM_VC-1:0]         credit_avail,
   output logic                      err_overflow,
   output logic                      err_underflow,
   output logic                      err_bad_vc
);

   logic [WIDTH-1:0] count_q [NUM_VC];
   logic [WIDTH-1:0] count_d [NUM_VC];
   logic [WIDTH-1:0] limit_q [NUM_VC];
   logic [WIDTH-1:0] limit_d [NUM_VC];
   logic             err_overflow_q,  err_overflow_d;
   logic             err_underflow_q, err_underflow_d;
   logic             err_bad_vc_q,    err_bad_vc_d;
   logic             inc, dec;

   // Next-state: config shift takes priority over counter updates.
   always_comb begin
      count_d         = count_q;
      limit_d         = limit_q;
      err_overflow_d  = err_overflow_q;
      err_underflow_d = err_underflow_q;
      err_bad_vc_d    = err_bad_vc_q;
      inc             = 1'b0;
      dec             = 1'b0;
      if (config_in_valid) begin
         // Each stage takes the downstream neighbour's count as both count and limit.
         for (int unsigned i = 0; i < NUM_VC - 1; i++) begin
            count_d[i] = count_q[i+1];
            limit_d[i] = count_q[i+1];
         end
         count_d[NUM_VC-1] = config_in;
         limit_d[NUM_VC-1] = config_in;
         err_overflow_d    = 1'b0;
         err_underflow_d   = 1'b0;
         err_bad_vc_d      = 1'b0;
      end else if (enable) begin
         if ((credit_in_valid && (32'(credit_in_vc) >= NUM_VC)) ||
             (dec_valid && (32'(dec_vc) >= NUM_VC))) begin
            err_bad_vc_d = 1'b1;
         end
         for (int unsigned v = 0; v < NUM_VC; v++) begin
            inc = credit_in_valid && (32'(credit_in_vc) == v);
            dec = dec_valid && (32'(dec_vc) == v);
            // Simultaneous inc and dec on one VC cancel out.
            if (inc && !dec) begin
               if (count_q[v] < limit_q[v]) count_d[v] = count_q[v] + WIDTH'(1);
               else                         err_overflow_d = 1'b1;
            end else if (dec && !inc) begin
               if (count_q[v] != '0) count_d[v] = count_q[v] - WIDTH'(1);
               else                  err_underflow_d = 1'b1;
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_VC; i++) begin
            count_q[i] <= '0;
            limit_q[i] <= '0;
         end
         err_overflow_q  <= 1'b0;
         err_underflow_q <= 1'b0;
         err_bad_vc_q    <= 1'b0;
      end else begin
         count_q         <= count_d;
         limit_q         <= limit_d;
         err_overflow_q  <= err_overflow_d;
         err_underflow_q <= err_underflow_d;
         err_bad_vc_q    <= err_bad_vc_d;
      end
   end

   // Output views of registered state.
   always_comb begin
      count_out    = '0;
      credit_avail = '0;
      for (int unsigned i = 0; i < NUM_VC; i++) begin
         count_out[i*WIDTH +: WIDTH] = count_q[i];
         credit_avail[i]             = (count_q[i] != '0);
      end
   end

   assign config_out       = count_q[0];
   assign config_out_valid = config_in_valid;
   assign credit_ack       = enable & credit_in_valid;
   assign err_overflow     = err_overflow_q;
   assign err_underflow    = err_underflow_q;
   assign err_bad_vc       = err_bad_vc_q;

endmodule

// File: tb/tb_credit_counter_bank.sv
// Self-checking bench for credit_counter_bank (NUM_VC=2, WIDTH=4, VC_BITS=2).
module tb_credit_counter_bank;

   localparam int unsigned NUM_VC  = 2;
   localparam int unsigned WIDTH   = 4;
   localparam int unsigned VC_BITS = 2;

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    enable;
   logic [WIDTH-1:0]        config_in;
   logic                    config_in_valid;
   logic [WIDTH-1:0]        config_out;
   logic                    config_out_valid;
   logic                    credit_in_valid;
   logic [VC_BITS-1:0]      credit_in_vc;
   logic                    credit_ack;
   logic                    dec_valid;
   logic [VC_BITS-1:0]      dec_vc;
   logic [NUM_VC*WIDTH-1:0] count_out;
   logic [NUM_VC-1:0]       credit_avail;
   logic                    err_overflow, err_underflow, err_bad_vc;

   int n_checks = 0;
   int n_pass   = 0;

   credit_counter_bank #(.NUM_VC(NUM_VC), .WIDTH(WIDTH), .VC_BITS(VC_BITS)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .config_in(config_in), .config_in_valid(config_in_valid),
      .config_out(config_out), .config_out_valid(config_out_valid),
      .credit_in_valid(credit_in_valid), .credit_in_vc(credit_in_vc),
      .credit_ack(credit_ack), .dec_valid(dec_valid), .dec_vc(dec_vc),
      .count_out(count_out), .credit_avail(credit_avail),
      .err_overflow(err_overflow), .err_underflow(err_underflow),
      .err_bad_vc(err_bad_vc)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst, en, cv;
      logic [3:0] cin;
      logic       iv;
      logic [1:0] ivc;
      logic       dv;
      logic [1:0] dvc;
      logic       e_ack;     // credit_ack before the edge
      logic [3:0] e_cfgo;    // config_out before the edge
      logic [7:0] e_cnt;     // count_out after the edge
      logic [1:0] e_av;      // credit_avail after the edge
      logic [2:0] e_err;     // {overflow, underflow, bad_vc} after the edge
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic en, logic cv, logic [3:0] cin,
                               logic iv, logic [1:0] ivc, logic dv, logic [1:0] dvc,
                               logic e_ack, logic [3:0] e_cfgo, logic [7:0] e_cnt,
                               logic [1:0] e_av, logic [2:0] e_err);
      vec_t v;
      v.rst = rst; v.en = en; v.cv = cv; v.cin = cin;
      v.iv = iv; v.ivc = ivc; v.dv = dv; v.dvc = dvc;
      v.e_ack = e_ack; v.e_cfgo = e_cfgo; v.e_cnt = e_cnt; v.e_av = e_av; v.e_err = e_err;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic drive(input logic rst, input logic en, input logic cv, input logic [3:0] cin,
                        input logic iv, input logic [1:0] ivc, input logic dv, input logic [1:0] dvc);
      reset = rst; enable = en; config_in_valid = cv; config_in = cin;
      credit_in_valid = iv; credit_in_vc = ivc; dec_valid = dv; dec_vc = dvc;
   endtask

   // Drive a vector just after an edge, check combinational outputs, clock, check state.
   task automatic apply(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      drive(v.rst, v.en, v.cv, v.cin, v.iv, v.ivc, v.dv, v.dvc);
      #1;
      check({tag, "_ack"},  32'(credit_ack), 32'(v.e_ack));
      check({tag, "_cov"},  32'(config_out_valid), 32'(v.cv));
      check({tag, "_cfgo"}, 32'(config_out), 32'(v.e_cfgo));
      @(posedge clock); #1;
      check({tag, "_cnt"},  32'(count_out), 32'(v.e_cnt));
      check({tag, "_av"},   32'(credit_avail), 32'(v.e_av));
      check({tag, "_err"},  32'({err_overflow, err_underflow, err_bad_vc}), 32'(v.e_err));
   endtask

   initial begin
      //            rst en cv cin  iv ivc dv dvc  ack cfgo cnt    av     err
      vecs.push_back(mk(0, 0, 1, 3,  0, 0, 0, 0,   0, 0, 8'h30, 2'b10, 3'b000));
      vecs.push_back(mk(0, 0, 1, 5,  0, 0, 0, 0,   0, 0, 8'h53, 2'b11, 3'b000));
      vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0,   0, 3, 8'h52, 2'b11, 3'b000));
      vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0,   0, 2, 8'h51, 2'b11, 3'b000));
      vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0,   0, 1, 8'h50, 2'b10, 3'b000));
      vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0,   0, 0, 8'h50, 2'b10, 3'b010));
      vecs.push_back(mk(0, 1, 0, 0,  1, 1, 0, 0,   1, 0, 8'h50, 2'b10, 3'b110));
      vecs.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1,   1, 0, 8'h50, 2'b10, 3'b110));
      vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 1,   0, 0, 8'h50, 2'b10, 3'b110));
      vecs.push_back(mk(0, 1, 0, 0,  1, 2, 0, 0,   1, 0, 8'h50, 2'b10, 3'b111));
      vecs.push_back(mk(0, 1, 0, 0,  1, 0, 1, 3,   1, 0, 8'h51, 2'b11, 3'b111));
      vecs.push_back(mk(0, 1, 1, 7,  1, 0, 1, 1,   1, 1, 8'h75, 2'b11, 3'b000));
      vecs.push_back(mk(0, 0, 1, 3,  0, 0, 0, 0,   0, 5, 8'h37, 2'b11, 3'b000));
      vecs.push_back(mk(0, 0, 1, 5,  0, 0, 0, 0,   0, 7, 8'h53, 2'b11, 3'b000));
      vecs.push_back(mk(0, 1, 0, 0,  1, 0, 1, 1,   1, 3, 8'h43, 2'b11, 3'b100));
      vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0,   0, 3, 8'h42, 2'b11, 3'b100));
      vecs.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0,   1, 2, 8'h43, 2'b11, 3'b100));
      vecs.push_back(mk(1, 1, 1, 9,  1, 0, 0, 0,   1, 3, 8'h00, 2'b00, 3'b000));
      vecs.push_back(mk(0, 0, 1, 9,  0, 0, 0, 0,   0, 0, 8'h90, 2'b10, 3'b000));
      vecs.push_back(mk(1, 0, 1, 4,  0, 0, 0, 0,   0, 0, 8'h00, 2'b00, 3'b000));
      vecs.push_back(mk(0, 0, 1, 1,  0, 0, 0, 0,   0, 0, 8'h10, 2'b10, 3'b000));
      vecs.push_back(mk(0, 0, 1, 15, 0, 0, 0, 0,   0, 0, 8'hF1, 2'b11, 3'b000));
      vecs.push_back(mk(0, 0, 1, 15, 0, 0, 0, 0,   0, 1, 8'hFF, 2'b11, 3'b000));

      // Reset state.
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1;
      check("rst_cnt", 32'(count_out), 32'h0);
      check("rst_av",  32'(credit_avail), 32'h0);
      check("rst_err", 32'({err_overflow, err_underflow, err_bad_vc}), 32'h0);

      foreach (vecs[i]) apply(vecs[i], i);

      // Both VCs now hold 15 with limit 15: drain VC0 to zero, underflow once,
      // refill to the limit and overflow once without wrapping.
      for (int k = 1; k <= 15; k++) begin
         drive(0, 1, 0, 0, 0, 0, 1, 0);
         @(posedge clock); #1;
         check($sformatf("drain%0d", k), 32'(count_out), 32'(8'hF0 | 8'(15 - k)));
      end
      drive(0, 1, 0, 0, 0, 0, 1, 0);
      @(posedge clock); #1;
      check("drain_floor_cnt", 32'(count_out), 32'h0F0);
      check("drain_floor_err", 32'({err_overflow, err_underflow, err_bad_vc}), 32'h2);
      check("drain_floor_av",  32'(credit_avail), 32'h2);
      for (int k = 1; k <= 15; k++) begin
         drive(0, 1, 0, 0, 1, 0, 0, 0);
         @(posedge clock); #1;
         check($sformatf("fill%0d", k), 32'(count_out), 32'(8'hF0 | 8'(k)));
      end
      drive(0, 1, 0, 0, 1, 0, 0, 0);
      @(posedge clock); #1;
      check("fill_sat_cnt", 32'(count_out), 32'h0FF);
      check("fill_sat_err", 32'({err_overflow, err_underflow, err_bad_vc}), 32'h6);

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
